// File: rtl/tt_um_alu_seq_host.sv
// tt_um_alu_seq_host
// Handshaked multi-cycle front-end for the 4-bit ALU on a TinyTapeout tile.
// A request is captured on start in IDLE and executed in EXEC:
//  - add/sub finish in one cycle.
//  - mul (shift-add) and div (restoring) take four iterations.
// The result is then held in DONE until the host acknowledges it.
//
// Ports
//   clk      clock
//   rst_n    asynchronous active-low reset
//   ena      tile enable (ignored)
//   ui_in    [3:0] operand A, [7:4] operand B
//   uio_in   [1:0] op (00 add, 01 sub, 10 mul, 11 div), [2] start, [3] ack,
//            [4] acc_sel (ALU_ACCUM_EN builds only)
//   uo_out   result register
//   uio_out  [5] done, [6] err (divide by zero), [7] flag (carry/borrow)
//   uio_oe   constant 8'hE0
//
// Build option: define ALU_ACCUM_EN so that acc_sel=1 at capture takes
// operand A from the low nibble of the previous result.
//
// state | meaning
// IDLE  | waiting for start; captures operands and op
// EXEC  | computing; one cycle for add/sub, four iterations for mul/div
// DONE  | result valid, done=1; waits for ack

module tt_um_alu_seq_host (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    logic [1:0] state;
    logic [3:0] a_reg;
    logic [3:0] b_reg;
    logic [1:0] op_reg;
    logic [1:0] iter;
    logic [7:0] prod_reg;
    logic [3:0] rem_reg;
    logic [3:0] quo_reg;
    logic       done;
    logic       err;
    logic       flag;

    logic       start;
    logic       ack;
    logic [3:0] a_capture;

    logic [7:0] sum;
    logic [7:0] diff;
    logic [7:0] mul_next;
    logic [4:0] rem_shift;
    logic       rem_ge;
    logic [4:0] rem_next;

    assign start = uio_in[2];
    assign ack   = uio_in[3];

`ifdef ALU_ACCUM_EN
    assign a_capture = uio_in[4] ? uo_out[3:0] : ui_in[3:0];
    wire unused_inputs = &{1'b0, ena, uio_in[7:5], rem_next[4]};
`else
    assign a_capture = ui_in[3:0];
    wire unused_inputs = &{1'b0, ena, uio_in[7:4], rem_next[4]};
`endif

    assign sum  = {4'd0, a_reg} + {4'd0, b_reg};
    assign diff = {4'd0, a_reg} - {4'd0, b_reg};

    // One shift-add step: add A shifted by the current B bit position.
    assign mul_next = prod_reg + (b_reg[iter] ? ({4'd0, a_reg} << iter) : 8'd0);

    // One restoring-divide step, dividend bits consumed MSB first.
    // With B=0 every compare succeeds, so quotient becomes 4'hF and the
    // remainder ends up equal to A without any special casing.
    assign rem_shift = {rem_reg, a_reg[2'd3 - iter]};
    assign rem_ge    = (rem_shift >= {1'b0, b_reg});
    assign rem_next  = rem_ge ? (rem_shift - {1'b0, b_reg}) : rem_shift;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            a_reg    <= 4'd0;
            b_reg    <= 4'd0;
            op_reg   <= 2'd0;
            iter     <= 2'd0;
            prod_reg <= 8'd0;
            rem_reg  <= 4'd0;
            quo_reg  <= 4'd0;
            uo_out   <= 8'd0;
            done     <= 1'b0;
            err      <= 1'b0;
            flag     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_reg    <= a_capture;
                        b_reg    <= ui_in[7:4];
                        op_reg   <= uio_in[1:0];
                        iter     <= 2'd0;
                        prod_reg <= 8'd0;
                        rem_reg  <= 4'd0;
                        quo_reg  <= 4'd0;
                        state    <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    case (op_reg)
                        OP_ADD: begin
                            uo_out <= sum;
                            flag   <= sum[4];
                            err    <= 1'b0;
                            done   <= 1'b1;
                            state  <= ST_DONE;
                        end
                        OP_SUB: begin
                            uo_out <= diff;
                            flag   <= (a_reg < b_reg);
                            err    <= 1'b0;
                            done   <= 1'b1;
                            state  <= ST_DONE;
                        end
                        OP_MUL: begin
                            prod_reg <= mul_next;
                            if (iter == 2'd3) begin
                                uo_out <= mul_next;
                                flag   <= 1'b0;
                                err    <= 1'b0;
                                done   <= 1'b1;
                                state  <= ST_DONE;
                            end else begin
                                iter <= iter + 2'd1;
                            end
                        end
                        OP_DIV: begin
                            rem_reg <= rem_next[3:0];
                            quo_reg <= {quo_reg[2:0], rem_ge};
                            if (iter == 2'd3) begin
                                uo_out <= {rem_next[3:0], quo_reg[2:0], rem_ge};
                                flag   <= 1'b0;
                                err    <= (b_reg == 4'd0);
                                done   <= 1'b1;
                                state  <= ST_DONE;
                            end else begin
                                iter <= iter + 2'd1;
                            end
                        end
                        default: state <= ST_IDLE;
                    endcase
                end
                ST_DONE: begin
                    if (ack) begin
                        done  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign uio_out = {flag, err, done, 5'd0};
    assign uio_oe  = 8'hE0;

endmodule

// File: tb/tb_tt_um_alu_seq_host.sv
module tb_tt_um_alu_seq_host;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int n_checks = 0;
    int n_pass   = 0;

    tt_um_alu_seq_host dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .ui_in  (ui_in),
        .uio_in (uio_in),
        .uo_out (uo_out),
        .uio_out(uio_out),
        .uio_oe (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    wire done_o = uio_out[5];
    wire err_o  = uio_out[6];
    wire flag_o = uio_out[7];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Launch one request and wait (bounded) for done; lat=-1 on timeout.
    task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op,
                          input logic acc, output int lat);
        ui_in  = {b, a};
        uio_in = {3'b000, acc, 1'b0, 1'b1, op};
        step();
        uio_in[2] = 1'b0;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (done_o === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic do_ack();
        uio_in[3] = 1'b1;
        step();
        uio_in[3] = 1'b0;
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        repeat (2) step();
        n_checks++;
        if (uo_out !== 8'h00) $display("FAIL reset_uo_out got=%h exp=00", uo_out); else n_pass++;
        n_checks++;
        if (uio_out !== 8'h00) $display("FAIL reset_uio_out got=%h exp=00", uio_out); else n_pass++;
        n_checks++;
        if (uio_oe !== 8'hE0) $display("FAIL reset_uio_oe got=%h exp=e0", uio_oe); else n_pass++;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_add();
        int lat;
        run_op(4'd9, 4'd8, 2'b00, 1'b0, lat);
        n_checks++;
        if (lat !== 1) $display("FAIL add_latency got=%0d exp=1", lat); else n_pass++;
        n_checks++;
        if (uo_out !== 8'h11) $display("FAIL add_result got=%h exp=11", uo_out); else n_pass++;
        n_checks++;
        if (flag_o !== 1'b1) $display("FAIL add_flag got=%b exp=1", flag_o); else n_pass++;
        n_checks++;
        if (err_o !== 1'b0) $display("FAIL add_err got=%b exp=0", err_o); else n_pass++;
        do_ack();
        n_checks++;
        if (done_o !== 1'b0) $display("FAIL add_ack_done got=%b exp=0", done_o); else n_pass++;
        n_checks++;
        if (uo_out !== 8'h11) $display("FAIL add_hold_after_ack got=%h exp=11", uo_out); else n_pass++;
    endtask

    task automatic test_sub();
        int lat;
        run_op(4'd3, 4'd5, 2'b01, 1'b0, lat);
        n_checks++;
        if (uo_out !== 8'hFE) $display("FAIL sub_wrap_result got=%h exp=fe", uo_out); else n_pass++;
        n_checks++;
        if (flag_o !== 1'b1) $display("FAIL sub_wrap_borrow got=%b exp=1", flag_o); else n_pass++;
        do_ack();
        run_op(4'd5, 4'd3, 2'b01, 1'b0, lat);
        n_checks++;
        if (uo_out !== 8'h02) $display("FAIL sub_result got=%h exp=02", uo_out); else n_pass++;
        n_checks++;
        if (flag_o !== 1'b0) $display("FAIL sub_borrow got=%b exp=0", flag_o); else n_pass++;
        do_ack();
    endtask

    task automatic test_mul();
        int lat;
        run_op(4'd15, 4'd15, 2'b10, 1'b0, lat);
        n_checks++;
        if (lat !== 4) $display("FAIL mul_latency got=%0d exp=4", lat); else n_pass++;
        n_checks++;
        if (uo_out !== 8'hE1) $display("FAIL mul_15x15 got=%h exp=e1", uo_out); else n_pass++;
        n_checks++;
        if (flag_o !== 1'b0) $display("FAIL mul_flag got=%b exp=0", flag_o); else n_pass++;
        do_ack();
        run_op(4'd6, 4'd5, 2'b10, 1'b0, lat);
        n_checks++;
        if (uo_out !== 8'h1E) $display("FAIL mul_6x5 got=%h exp=1e", uo_out); else n_pass++;
        do_ack();
    endtask

    task automatic test_div();
        int lat;
        run_op(4'd13, 4'd4, 2'b11, 1'b0, lat);
        n_checks++;
        if (lat !== 4) $display("FAIL div_latency got=%0d exp=4", lat); else n_pass++;
        n_checks++;
        if (uo_out !== 8'h13) $display("FAIL div_13_4 got=%h exp=13", uo_out); else n_pass++;
        n_checks++;
        if (err_o !== 1'b0) $display("FAIL div_err got=%b exp=0", err_o); else n_pass++;
        do_ack();
        run_op(4'd7, 4'd0, 2'b11, 1'b0, lat);
        n_checks++;
        if (lat !== 4) $display("FAIL div0_latency got=%0d exp=4", lat); else n_pass++;
        n_checks++;
        if (uo_out !== 8'h7F) $display("FAIL div0_result got=%h exp=7f", uo_out); else n_pass++;
        n_checks++;
        if (err_o !== 1'b1) $display("FAIL div0_err got=%b exp=1", err_o); else n_pass++;
        do_ack();
    endtask

    task automatic test_protocol();
        int bad;
        // mul 3*7 = 21; noise on start/operands during EXEC and DONE
        ui_in  = {4'd7, 4'd3};
        uio_in = 8'b0000_0110;
        step();
        for (int i = 0; i < 6; i++) begin
            ui_in  = 8'hFF - 8'(i);
            uio_in = {5'b00000, ~uio_in[2], 2'b00};
            step();
        end
        uio_in = 8'h00;
        n_checks++;
        if (done_o !== 1'b1) $display("FAIL proto_done got=%b exp=1", done_o); else n_pass++;
        n_checks++;
        if (uo_out !== 8'h15) $display("FAIL proto_result got=%h exp=15", uo_out); else n_pass++;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (done_o !== 1'b1 || uo_out !== 8'h15) bad++;
        end
        n_checks++;
        if (bad != 0) $display("FAIL proto_hold_stable bad_cycles=%0d exp=0", bad); else n_pass++;
        do_ack();
        n_checks++;
        if (done_o !== 1'b0) $display("FAIL proto_ack got=%b exp=0", done_o); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [4:0] pat;
        logic [4:0] exp_pat;
        exp_pat = 5'b10010;   // done after edges k..k+4: 0,1,0,0,1 (LSB first)
        // ack and start held: DONE->IDLE edge must not capture, next edge does
        ui_in  = {4'd2, 4'd1};
        uio_in = 8'b0000_1100;
        for (int i = 0; i < 5; i++) begin
            step();
            pat[i] = done_o;
        end
        n_checks++;
        if (pat !== exp_pat) $display("FAIL b2b_done_pattern got=%b exp=%b", pat, exp_pat); else n_pass++;
        n_checks++;
        if (uo_out !== 8'h03) $display("FAIL b2b_result got=%h exp=03", uo_out); else n_pass++;
        uio_in = 8'b0000_1000;
        step();
        uio_in = 8'h00;
        n_checks++;
        if (done_o !== 1'b0) $display("FAIL b2b_release got=%b exp=0", done_o); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int lat;
        ui_in  = {4'd15, 4'd15};
        uio_in = 8'b0000_0110;
        step();
        uio_in = 8'h00;
        repeat (2) step();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (uo_out !== 8'h00) $display("FAIL midreset_uo_out got=%h exp=00", uo_out); else n_pass++;
        n_checks++;
        if (uio_out !== 8'h00) $display("FAIL midreset_uio_out got=%h exp=00", uio_out); else n_pass++;
        step();
        rst_n = 1'b1;
        step();
        run_op(4'd2, 4'd3, 2'b00, 1'b0, lat);
        n_checks++;
        if (lat !== 1 || uo_out !== 8'h05)
            $display("FAIL post_reset_add got=%h lat=%0d exp=05 lat=1", uo_out, lat);
        else n_pass++;
        do_ack();
        // acc_sel=1 with ui_in A=9, B=4
        run_op(4'd9, 4'd4, 2'b10, 1'b1, lat);
        n_checks++;
`ifdef ALU_ACCUM_EN
        if (uo_out !== 8'h14) $display("FAIL accum_mul got=%h exp=14", uo_out); else n_pass++;
`else
        if (uo_out !== 8'h24) $display("FAIL accsel_ignored got=%h exp=24", uo_out); else n_pass++;
`endif
        do_ack();
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_mul();
        test_div();
        test_protocol();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
